// File: rtl/rv32i_memu_pkg.sv
// Shared definitions for the RV32I memory-access stage: write-back select
// codes, access-size codes, the bus FSM state type and an alignment helper.
package rv32i_memu_pkg;

  // Write-back source select
  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;
  localparam logic [1:0] WB_SEL_IMM  = 2'b11;

  // Access size, funct3[1:0]
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_GNT    = 2'd1,
    ST_WAIT_RVALID = 2'd2
  } memu_state_e;

  // Halves need an even address, words (and the unused 11 code) a multiple of four.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr_lo[0];
      SIZE_WORD: mis = (addr_lo != 2'b00);
      default:   mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/rv32i_memu_align.sv
// Byte-lane steering: store data replication and byte enables, and load lane
// extraction with sign or zero extension.
module rv32i_memu_align
  import rv32i_memu_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_be_o,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_signed;

  // Store: replicate the low byte/half across the word, enable only the addressed lanes
  always_comb begin
    st_wdata_o = st_data_i;
    st_be_o    = 4'b1111;
    case (funct3_i[1:0])
      SIZE_BYTE: begin
        st_wdata_o = {4{st_data_i[7:0]}};
        st_be_o    = 4'b0001 << addr_lo_i;
      end
      SIZE_HALF: begin
        st_wdata_o = {2{st_data_i[15:0]}};
        st_be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
      end
      default: begin
        st_wdata_o = st_data_i;
        st_be_o    = 4'b1111;
      end
    endcase
  end

  assign ld_shifted = ld_rdata_i >> {addr_lo_i, 3'b000};
  assign ld_byte    = ld_shifted[7:0];
  assign ld_half    = ld_shifted[15:0];
  assign ld_signed  = ~funct3_i[2];

  // Load: move the addressed lane down to bit 0, then extend
  always_comb begin
    ld_data_o = ld_rdata_i;
    case (funct3_i[1:0])
      SIZE_BYTE: ld_data_o = {{24{ld_byte[7] & ld_signed}}, ld_byte};
      SIZE_HALF: ld_data_o = {{16{ld_half[15] & ld_signed}}, ld_half};
      default:   ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/rv32i_memu.sv
// Memory-access stage: data-bus handshake for loads/stores, branch redirect,
// result forwarding to execute and the write-back pipeline register.
module rv32i_memu
  import rv32i_memu_pkg::*;
#(
  parameter int WORD_WTH    = 32,
  parameter int ADDR_WTH    = 32,
  parameter int WB_MUX_WTH  = 2,
  parameter int REG_INX_WTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_WTH-1:0]    mem_alu_res_i,
  input  logic [WORD_WTH-1:0]    mem_imm_i,
  input  logic [ADDR_WTH-1:0]    mem_pc_plus_imm_i,
  input  logic [ADDR_WTH-1:0]    mem_pc_plus_4_i,
  input  logic [WORD_WTH-1:0]    mem_rdata2_i,
  input  logic [REG_INX_WTH-1:0] mem_rd_inx_i,
  input  logic [2:0]             mem_funct3_i,
  input  logic                   mem_br_taken_i,
  input  logic                   mem_RegW_EN_i,
  input  logic                   mem_MemW_EN_i,
  input  logic                   mem_TakenAddr_sel_i,
  input  logic                   mem_auipc_sel_i,
  input  logic [WB_MUX_WTH-1:0]  mem_RegW_sel_i,
  output logic                   dbus_req_o,
  output logic                   dbus_we_o,
  output logic [ADDR_WTH-1:0]    dbus_addr_o,
  output logic [3:0]             dbus_be_o,
  output logic [WORD_WTH-1:0]    dbus_wdata_o,
  input  logic                   dbus_gnt_i,
  input  logic                   dbus_rvalid_i,
  input  logic [WORD_WTH-1:0]    dbus_rdata_i,
  output logic                   mem_redirect_o,
  output logic [ADDR_WTH-1:0]    mem_redirect_pc_o,
  output logic                   mem_stall_o,
  output logic                   mem_misalign_o,
  output logic [WORD_WTH-1:0]    mem_fd_o,
  output logic [REG_INX_WTH-1:0] mem_rd_inx_har_o,
  output logic                   mem_RegW_EN_har_o,
  output logic [WORD_WTH-1:0]    wb_data_o,
  output logic [REG_INX_WTH-1:0] wb_rd_inx_o,
  output logic                   wb_RegW_EN_o
);

  memu_state_e state_q, state_d;

  logic [WORD_WTH-1:0]    wb_data_q, wb_data_d;
  logic [REG_INX_WTH-1:0] wb_rd_inx_q, wb_rd_inx_d;
  logic                   wb_RegW_EN_q, wb_RegW_EN_d;

  logic                is_load, is_store, is_access;
  logic                addr_misaligned, misalign_raw;
  logic                req, stall;
  logic [WORD_WTH-1:0] nl_res;
  logic [31:0]         st_wdata, ld_data;
  logic [3:0]          st_be;

  assign is_load         = mem_RegW_EN_i && (mem_RegW_sel_i == WB_SEL_LOAD);
  assign is_store        = mem_MemW_EN_i;
  assign is_access       = is_load || is_store;
  assign addr_misaligned = is_misaligned(mem_funct3_i[1:0], mem_alu_res_i[1:0]);
  assign misalign_raw    = is_access && addr_misaligned;

  rv32i_memu_align u_align (
    .addr_lo_i  (mem_alu_res_i[1:0]),
    .funct3_i   (mem_funct3_i),
    .st_data_i  (mem_rdata2_i),
    .ld_rdata_i (dbus_rdata_i),
    .st_wdata_o (st_wdata),
    .st_be_o    (st_be),
    .ld_data_o  (ld_data)
  );

  // Result of non-load instructions, also forwarded straight to execute
  always_comb begin
    nl_res = mem_alu_res_i;
    case (mem_RegW_sel_i)
      WB_SEL_ALU:  nl_res = mem_auipc_sel_i ? mem_pc_plus_imm_i : mem_alu_res_i;
      WB_SEL_PC4:  nl_res = mem_pc_plus_4_i;
      WB_SEL_IMM:  nl_res = mem_imm_i;
      default:     nl_res = mem_alu_res_i;
    endcase
  end

  // Bus FSM next state; stall whenever the access does not finish this cycle
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_access && !addr_misaligned) begin
          req = 1'b1;
          if (dbus_gnt_i) begin
            if (is_load) begin
              state_d = ST_WAIT_RVALID;
              stall   = 1'b1;
            end
          end else begin
            state_d = ST_WAIT_GNT;
            stall   = 1'b1;
          end
        end
      end
      ST_WAIT_GNT: begin
        req   = 1'b1;
        stall = 1'b1;
        if (dbus_gnt_i) begin
          if (is_load) begin
            state_d = ST_WAIT_RVALID;
          end else begin
            state_d = ST_IDLE;
            stall   = 1'b0;
          end
        end
      end
      ST_WAIT_RVALID: begin
        if (dbus_rvalid_i) state_d = ST_IDLE;
        else               stall   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write-back register input: bubble while stalled, misaligned accesses never write
  always_comb begin
    wb_data_d    = nl_res;
    wb_rd_inx_d  = mem_rd_inx_i;
    wb_RegW_EN_d = 1'b0;
    if (!stall) begin
      wb_RegW_EN_d = mem_RegW_EN_i && !misalign_raw;
      if (is_load) wb_data_d = ld_data;
    end
  end

  // State and write-back pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wb_data_q    <= '0;
      wb_rd_inx_q  <= '0;
      wb_RegW_EN_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wb_data_q    <= wb_data_d;
      wb_rd_inx_q  <= wb_rd_inx_d;
      wb_RegW_EN_q <= wb_RegW_EN_d;
    end
  end

  // Control outputs are forced quiet for the whole time reset is held
  assign dbus_req_o        = req && !rst;
  assign dbus_we_o         = req && is_store && !rst;
  assign dbus_be_o         = (req && !rst) ? (is_store ? st_be : 4'b1111) : 4'b0000;
  assign dbus_addr_o       = {mem_alu_res_i[ADDR_WTH-1:2], 2'b00};
  assign dbus_wdata_o      = st_wdata;
  assign mem_stall_o       = stall && !rst;
  assign mem_misalign_o    = misalign_raw && (state_q == ST_IDLE) && !rst;
  assign mem_redirect_o    = mem_br_taken_i && !rst;
  assign mem_redirect_pc_o = mem_TakenAddr_sel_i ? {mem_alu_res_i[ADDR_WTH-1:1], 1'b0}
                                                 : mem_pc_plus_imm_i;
  assign mem_fd_o          = nl_res;
  assign mem_rd_inx_har_o  = mem_rd_inx_i;
  assign mem_RegW_EN_har_o = mem_RegW_EN_i;
  assign wb_data_o         = wb_data_q;
  assign wb_rd_inx_o       = wb_rd_inx_q;
  assign wb_RegW_EN_o      = wb_RegW_EN_q;

endmodule

// File: tb/tb_rv32i_memu.sv
// Scoreboard bench for rv32i_memu: stimulus pushes expected bus transfers and
// write-backs into queues; a monitor pops and compares them as the DUT emits them.
module tb_rv32i_memu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_res, imm, pc_plus_imm, pc_plus_4, rdata2;
  logic [4:0]  rd_inx;
  logic [2:0]  funct3;
  logic        br_taken, regw_en, memw_en, taken_sel, auipc_sel;
  logic [1:0]  regw_sel;
  logic        dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_be_o;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic        mem_redirect_o, mem_stall_o, mem_misalign_o;
  logic [31:0] mem_redirect_pc_o, mem_fd_o;
  logic [4:0]  mem_rd_inx_har_o;
  logic        mem_RegW_EN_har_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_inx_o;
  logic        wb_RegW_EN_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } bus_exp_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
  } wb_exp_t;

  bus_exp_t bus_q[$];
  wb_exp_t  wb_q[$];
  bus_exp_t mon_bus;
  wb_exp_t  mon_wb;

  always #5 clk = ~clk;

  rv32i_memu dut (
    .clk                 (clk),
    .rst                 (rst),
    .mem_alu_res_i       (alu_res),
    .mem_imm_i           (imm),
    .mem_pc_plus_imm_i   (pc_plus_imm),
    .mem_pc_plus_4_i     (pc_plus_4),
    .mem_rdata2_i        (rdata2),
    .mem_rd_inx_i        (rd_inx),
    .mem_funct3_i        (funct3),
    .mem_br_taken_i      (br_taken),
    .mem_RegW_EN_i       (regw_en),
    .mem_MemW_EN_i       (memw_en),
    .mem_TakenAddr_sel_i (taken_sel),
    .mem_auipc_sel_i     (auipc_sel),
    .mem_RegW_sel_i      (regw_sel),
    .dbus_req_o          (dbus_req_o),
    .dbus_we_o           (dbus_we_o),
    .dbus_addr_o         (dbus_addr_o),
    .dbus_be_o           (dbus_be_o),
    .dbus_wdata_o        (dbus_wdata_o),
    .dbus_gnt_i          (gnt),
    .dbus_rvalid_i       (rvalid),
    .dbus_rdata_i        (rdata),
    .mem_redirect_o      (mem_redirect_o),
    .mem_redirect_pc_o   (mem_redirect_pc_o),
    .mem_stall_o         (mem_stall_o),
    .mem_misalign_o      (mem_misalign_o),
    .mem_fd_o            (mem_fd_o),
    .mem_rd_inx_har_o    (mem_rd_inx_har_o),
    .mem_RegW_EN_har_o   (mem_RegW_EN_har_o),
    .wb_data_o           (wb_data_o),
    .wb_rd_inx_o         (wb_rd_inx_o),
    .wb_RegW_EN_o        (wb_RegW_EN_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic push_bus(input logic [31:0] a, input logic [3:0] b, input logic [31:0] w,
                          input logic we);
    bus_exp_t e;
    e.addr = a; e.be = b; e.wdata = w; e.we = we;
    bus_q.push_back(e);
  endtask

  task automatic push_wb(input logic [31:0] d, input logic [4:0] r);
    wb_exp_t e;
    e.data = d; e.rd = r;
    wb_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic bubble();
    br_taken = 1'b0; regw_en = 1'b0; memw_en = 1'b0; taken_sel = 1'b0;
    auipc_sel = 1'b0; regw_sel = 2'b00; funct3 = 3'b000; rd_inx = 5'd0;
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
  endtask

  // Load with gnt in the issue cycle and rvalid in the next
  task automatic load_zero_wait(input string name, input logic [31:0] addr, input logic [2:0] f3,
                                input logic [4:0] rd, input logic [31:0] rd_data,
                                input logic [31:0] exp);
    next_cycle();
    bubble();
    alu_res = addr; funct3 = f3; regw_en = 1'b1; regw_sel = 2'b01; rd_inx = rd;
    gnt = 1'b1;
    push_bus({addr[31:2], 2'b00}, 4'b1111, 32'h0, 1'b0);
    sample();
    chk({name, "_stall_c0"}, 32'(mem_stall_o), 32'd1);
    next_cycle();
    gnt = 1'b0; rvalid = 1'b1; rdata = rd_data;
    push_wb(exp, rd);
    sample();
    chk({name, "_stall_c1"}, 32'(mem_stall_o), 32'd0);
  endtask

  // Monitor: compare every granted bus transfer and every write-back against the queues
  always @(negedge clk) begin
    if (!rst) begin
      if (dbus_req_o && gnt) begin
        if (bus_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_bus: got addr 0x%08h expected no transfer", dbus_addr_o);
        end else begin
          mon_bus = bus_q.pop_front();
          chk("bus_addr", dbus_addr_o, mon_bus.addr);
          chk("bus_be", 32'(dbus_be_o), 32'(mon_bus.be));
          chk("bus_we", 32'(dbus_we_o), 32'(mon_bus.we));
          if (mon_bus.we) chk("bus_wdata", dbus_wdata_o, mon_bus.wdata);
        end
      end
      if (wb_RegW_EN_o) begin
        if (wb_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_wb: got data 0x%08h rd %0d expected no write", wb_data_o, wb_rd_inx_o);
        end else begin
          mon_wb = wb_q.pop_front();
          chk("wb_data", wb_data_o, mon_wb.data);
          chk("wb_rd", 32'(wb_rd_inx_o), 32'(mon_wb.rd));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] nm_alu [4];
  logic [1:0]  nm_sel [4];
  logic        nm_aui [4];
  logic [31:0] nm_exp [4];
  int          stall_cnt, req_cnt;

  initial begin
    nm_alu = '{32'h10, 32'h77, 32'h55, 32'h66};
    nm_sel = '{2'b00, 2'b00, 2'b10, 2'b11};
    nm_aui = '{1'b0, 1'b1, 1'b0, 1'b0};
    nm_exp = '{32'h10, 32'h2000, 32'h44, 32'hDEAD0000};

    imm = 32'hDEAD0000; pc_plus_imm = 32'h2000; pc_plus_4 = 32'h44; rdata2 = 32'h0;
    bubble();
    // During reset, a store and a taken branch are presented; outputs must stay quiet
    rst = 1'b1;
    alu_res = 32'h1000; memw_en = 1'b1; funct3 = 3'b010; br_taken = 1'b1; gnt = 1'b1;
    sample();
    chk("rst_req", 32'(dbus_req_o), 32'd0);
    chk("rst_we", 32'(dbus_we_o), 32'd0);
    chk("rst_be", 32'(dbus_be_o), 32'd0);
    chk("rst_stall", 32'(mem_stall_o), 32'd0);
    chk("rst_redirect", 32'(mem_redirect_o), 32'd0);
    chk("rst_wb_en", 32'(wb_RegW_EN_o), 32'd0);
    chk("rst_wb_data", wb_data_o, 32'd0);
    chk("rst_wb_rd", 32'(wb_rd_inx_o), 32'd0);
    next_cycle();
    bubble();
    rst = 1'b0;

    // Non-memory instructions: alu, auipc, pc+4, imm
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      bubble();
      alu_res = nm_alu[i]; regw_sel = nm_sel[i]; auipc_sel = nm_aui[i];
      regw_en = 1'b1; rd_inx = 5'(i + 1);
      push_wb(nm_exp[i], 5'(i + 1));
      sample();
      chk("nm_fd", mem_fd_o, nm_exp[i]);
      chk("nm_req", 32'(dbus_req_o), 32'd0);
      chk("nm_rd_har", 32'(mem_rd_inx_har_o), 32'(i + 1));
      chk("nm_en_har", 32'(mem_RegW_EN_har_o), 32'd1);
    end

    // sb to 0x1003 with immediate grant
    next_cycle();
    bubble();
    alu_res = 32'h1003; rdata2 = 32'h123456AB; memw_en = 1'b1; funct3 = 3'b000; gnt = 1'b1;
    push_bus(32'h1000, 4'b1000, 32'hABABABAB, 1'b1);
    sample();
    chk("sb_stall", 32'(mem_stall_o), 32'd0);
    chk("sb_req", 32'(dbus_req_o), 32'd1);

    // sh to 0x1002, grant one cycle late: request must hold lanes stable
    next_cycle();
    bubble();
    alu_res = 32'h1002; rdata2 = 32'h00001234; memw_en = 1'b1; funct3 = 3'b001;
    sample();
    chk("sh_stall_wait", 32'(mem_stall_o), 32'd1);
    chk("sh_be_wait", 32'(dbus_be_o), 32'hC);
    next_cycle();
    gnt = 1'b1;
    push_bus(32'h1000, 4'b1100, 32'h12341234, 1'b1);
    sample();
    chk("sh_stall_gnt", 32'(mem_stall_o), 32'd0);

    // sw to 0x1004 with immediate grant
    next_cycle();
    bubble();
    alu_res = 32'h1004; rdata2 = 32'hCAFEF00D; memw_en = 1'b1; funct3 = 3'b010; gnt = 1'b1;
    push_bus(32'h1004, 4'b1111, 32'hCAFEF00D, 1'b1);
    sample();
    chk("sw_stall", 32'(mem_stall_o), 32'd0);

    // lh signed from 0x2002: gnt in cycle 2, rvalid in cycle 3
    next_cycle();
    bubble();
    alu_res = 32'h2002; funct3 = 3'b001; regw_en = 1'b1; regw_sel = 2'b01; rd_inx = 5'd7;
    stall_cnt = 0; req_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) next_cycle();
      gnt    = (c == 2);
      rvalid = (c == 3);
      rdata  = (c == 3) ? 32'h80010000 : 32'h0;
      if (c == 2) push_bus(32'h2000, 4'b1111, 32'h0, 1'b0);
      if (c == 3) push_wb(32'hFFFF8001, 5'd7);
      sample();
      if (mem_stall_o) stall_cnt++;
      if (dbus_req_o) req_cnt++;
    end
    chk("lh_stall_cycles", 32'(stall_cnt), 32'd3);
    chk("lh_req_cycles", 32'(req_cnt), 32'd3);

    // Zero-wait loads with various sizes and extension
    load_zero_wait("lbu", 32'h2001, 3'b100, 5'd8, 32'h123480FF, 32'h00000080);
    load_zero_wait("lb", 32'h2001, 3'b000, 5'd9, 32'h123480FF, 32'hFFFFFF80);
    load_zero_wait("lhu", 32'h2002, 3'b101, 5'd10, 32'h80010000, 32'h00008001);
    load_zero_wait("lw", 32'h3000, 3'b010, 5'd11, 32'hCAFEBABE, 32'hCAFEBABE);

    // Misaligned lw: pulse, no request, no write-back
    next_cycle();
    bubble();
    alu_res = 32'h3001; funct3 = 3'b010; regw_en = 1'b1; regw_sel = 2'b01; rd_inx = 5'd9;
    sample();
    chk("lw_mis_pulse", 32'(mem_misalign_o), 32'd1);
    chk("lw_mis_req", 32'(dbus_req_o), 32'd0);
    chk("lw_mis_stall", 32'(mem_stall_o), 32'd0);
    next_cycle();
    bubble();
    sample();
    chk("lw_mis_pulse_end", 32'(mem_misalign_o), 32'd0);
    chk("lw_mis_wb_en", 32'(wb_RegW_EN_o), 32'd0);

    // Misaligned sh
    next_cycle();
    bubble();
    alu_res = 32'h1001; funct3 = 3'b001; memw_en = 1'b1; gnt = 1'b1;
    sample();
    chk("sh_mis_pulse", 32'(mem_misalign_o), 32'd1);
    chk("sh_mis_req", 32'(dbus_req_o), 32'd0);

    // jalr: target from alu_res with bit 0 cleared, links pc+4
    next_cycle();
    bubble();
    alu_res = 32'h105; taken_sel = 1'b1; br_taken = 1'b1; regw_en = 1'b1;
    regw_sel = 2'b10; pc_plus_4 = 32'h208; rd_inx = 5'd1;
    push_wb(32'h208, 5'd1);
    sample();
    chk("jalr_redirect", 32'(mem_redirect_o), 32'd1);
    chk("jalr_pc", mem_redirect_pc_o, 32'h104);

    // Taken branch: target is pc+imm
    next_cycle();
    bubble();
    pc_plus_imm = 32'h400; br_taken = 1'b1;
    sample();
    chk("br_redirect", 32'(mem_redirect_o), 32'd1);
    chk("br_pc", mem_redirect_pc_o, 32'h400);
    next_cycle();
    bubble();
    sample();
    chk("br_redirect_off", 32'(mem_redirect_o), 32'd0);

    // Reset while waiting for rvalid; the late rvalid must be dropped
    next_cycle();
    bubble();
    alu_res = 32'h4000; funct3 = 3'b010; regw_en = 1'b1; regw_sel = 2'b01; rd_inx = 5'd12;
    gnt = 1'b1;
    push_bus(32'h4000, 4'b1111, 32'h0, 1'b0);
    sample();
    next_cycle();
    gnt = 1'b0;
    sample();
    chk("rstmid_stall_before", 32'(mem_stall_o), 32'd1);
    next_cycle();
    rst = 1'b1;
    bubble();
    sample();
    chk("rstmid_stall", 32'(mem_stall_o), 32'd0);
    chk("rstmid_req", 32'(dbus_req_o), 32'd0);
    chk("rstmid_wb_en", 32'(wb_RegW_EN_o), 32'd0);
    next_cycle();
    rst = 1'b0;
    rvalid = 1'b1; rdata = 32'hFFFFFFFF;
    sample();
    chk("late_rvalid_stall", 32'(mem_stall_o), 32'd0);
    next_cycle();
    bubble();
    sample();
    chk("late_rvalid_wb_en", 32'(wb_RegW_EN_o), 32'd0);

    next_cycle();
    sample();
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    chk("wb_q_drained", 32'(wb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
